cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter_pkg.sv | 14 +
 rtl/arb_tag_fifo.sv | 64 ++++++
 rtl/cpu_mem_arbiter.sv | 93 +++++++++
 tb/tb_cpu_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared constants for the CPU memory arbiter: route-tag values and the
// access-size encodings used on the data side and on the downstream port.
package cpu_mem_arbiter_pkg;

    // Route tag stored per accepted request, read back when its response arrives.
    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    // Access size encodings.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit route-tag FIFO for the CPU memory arbiter.
// A push while full and a pop while empty are both ignored; the arbiter
// never pushes when full, and a pop while empty is a stray response.
module arb_tag_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic head_tag,
    output logic full,
    output logic empty
);

    // Depth 1 still needs a 1-bit pointer; it simply never leaves 0.
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status flags, qualified push/pop and the head-of-queue tag.
    always_comb begin
        full     = (count_q == CntW'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        head_tag = mem_q[rd_ptr_q];
    end

    // Tag storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Two-master (instruction / data) arbiter onto one pipelined memory port.
// Grant is combinational; each accepted request pushes a source tag so that
// in-order responses are steered back to the right master with no latency.
// Build option: define ARB_INST_PRIO_EN to make instruction fetches win ties;
// by default the data side wins.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic grant_data;
    logic grant_inst;
    logic req_ok;
    logic push;
    logic push_tag;
    logic pop;
    logic head_tag;
    logic fifo_full;
    logic fifo_empty;

    // Pick a winner, drive the downstream request and route responses back.
    always_comb begin
`ifdef ARB_INST_PRIO_EN
        grant_data = data_req & ~inst_req;
`else
        grant_data = data_req;
`endif
        grant_inst = inst_req & ~grant_data;

        // No new request while the tag FIFO is full or reset is held.
        req_ok   = resetn & ~fifo_full;
        mem_req  = req_ok & (inst_req | data_req);
        mem_wr   = grant_data ? data_wr : 1'b0;
        mem_size = grant_data ? data_size : SIZE_WORD;
        mem_addr = grant_data ? data_addr : inst_addr;
        mem_wdata = data_wdata;

        inst_addr_ok = req_ok & grant_inst & mem_addr_ok;
        data_addr_ok = req_ok & grant_data & mem_addr_ok;

        push     = mem_req & mem_addr_ok;
        push_tag = grant_data ? TAG_DATA : TAG_INST;

        // A response with nothing outstanding is dropped.
        pop          = resetn & mem_data_ok & ~fifo_empty;
        inst_data_ok = pop & (head_tag == TAG_INST);
        data_data_ok = pop & (head_tag == TAG_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter (MAX_OUT = 2).
// Expectations follow the ARB_INST_PRIO_EN setting of the build.
module tb_cpu_mem_arbiter;

`ifdef ARB_INST_PRIO_EN
    localparam bit InstPrio = 1'b1;
`else
    localparam bit InstPrio = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_fail;

    cpu_mem_arbiter #(
        .MAX_OUT (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fifo_count();
        return 32'(dut.u_tag_fifo.count_q);
    endfunction

    logic        exp_tag;
    logic        src;
    logic        model[$];
    logic [31:0] first_addr;
    logic [31:0] second_addr;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0;

        // Reset state: outputs quiet even with requests and responses present.
        repeat (2) step();
        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
        check_eq("rst_data_addr_ok", 32'(data_addr_ok), 0);
        check_eq("rst_inst_data_ok", 32'(inst_data_ok), 0);
        check_eq("rst_data_data_ok", 32'(data_data_ok), 0);
        check_eq("rst_count", fifo_count(), 0);
        inst_req    = 1'b0;
        mem_data_ok = 1'b0;
        resetn      = 1'b1;
        step();

        // Both request together: tie-break by build priority.
        inst_req  = 1'b1;
        inst_addr = 32'h2000;
        data_req  = 1'b1;
        data_addr = 32'h1000;
        first_addr  = InstPrio ? 32'h2000 : 32'h1000;
        second_addr = InstPrio ? 32'h1000 : 32'h2000;
        #1;
        check_eq("tie_mem_req", 32'(mem_req), 1);
        check_eq("tie_mem_addr", mem_addr, first_addr);
        check_eq("tie_data_addr_ok", 32'(data_addr_ok), 32'(!InstPrio));
        check_eq("tie_inst_addr_ok", 32'(inst_addr_ok), 32'(InstPrio));
        step();
        check_eq("tie_count1", fifo_count(), 1);
        if (InstPrio) inst_req = 1'b0;
        else data_req = 1'b0;
        #1;
        check_eq("tie2_mem_addr", mem_addr, second_addr);
        check_eq("tie2_inst_addr_ok", 32'(inst_addr_ok), 32'(!InstPrio));
        check_eq("tie2_data_addr_ok", 32'(data_addr_ok), 32'(InstPrio));
        check_eq("tie2_mem_size", 32'(mem_size), 2);
        check_eq("tie2_mem_wr", 32'(mem_wr), 0);
        step();
        check_eq("tie_count2", fifo_count(), 2);

        // Third request stalls while two are outstanding.
        inst_req  = 1'b1;
        inst_addr = 32'h3000;
        data_req  = 1'b0;
        #1;
        check_eq("full_mem_req", 32'(mem_req), 0);
        check_eq("full_inst_addr_ok", 32'(inst_addr_ok), 0);
        step();
        check_eq("full_mem_req_hold", 32'(mem_req), 0);
        check_eq("full_count", fifo_count(), 2);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        #1;
        check_eq("pop1_inst_data_ok", 32'(inst_data_ok), 32'(InstPrio));
        check_eq("pop1_data_data_ok", 32'(data_data_ok), 32'(!InstPrio));
        check_eq("pop1_rdata", InstPrio ? inst_rdata : data_rdata, 32'h1111_1111);
        check_eq("pop1_mem_req", 32'(mem_req), 0);
        step();
        check_eq("pop1_count", fifo_count(), 1);
        mem_rdata = 32'h2222_2222;
        #1;
        check_eq("unstall_mem_req", 32'(mem_req), 1);
        check_eq("unstall_inst_addr_ok", 32'(inst_addr_ok), 1);
        check_eq("pop2_inst_data_ok", 32'(inst_data_ok), 32'(!InstPrio));
        check_eq("pop2_data_data_ok", 32'(data_data_ok), 32'(InstPrio));
        step();
        check_eq("pushpop_count", fifo_count(), 1);
        inst_req  = 1'b0;
        mem_rdata = 32'h3333_3333;
        #1;
        check_eq("pop3_inst_data_ok", 32'(inst_data_ok), 1);
        check_eq("pop3_inst_rdata", inst_rdata, 32'h3333_3333);
        step();
        mem_data_ok = 1'b0;
        check_eq("drain_count", fifo_count(), 0);

        // Inst read then data byte write, responses routed in order.
        inst_req  = 1'b1;
        inst_addr = 32'h5000;
        #1;
        check_eq("rw_inst_addr_ok", 32'(inst_addr_ok), 1);
        check_eq("rw_inst_mem_wr", 32'(mem_wr), 0);
        step();
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd0;
        data_addr  = 32'h4001;
        data_wdata = 32'h0000_00A5;
        #1;
        check_eq("rw_data_addr_ok", 32'(data_addr_ok), 1);
        check_eq("rw_mem_wr", 32'(mem_wr), 1);
        check_eq("rw_mem_size", 32'(mem_size), 0);
        check_eq("rw_mem_addr", mem_addr, 32'h4001);
        check_eq("rw_mem_wdata", mem_wdata, 32'h0000_00A5);
        step();
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        #1;
        check_eq("rw_inst_data_ok", 32'(inst_data_ok), 1);
        check_eq("rw_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
        check_eq("rw_data_data_ok0", 32'(data_data_ok), 0);
        step();
        mem_rdata = 32'h0;
        #1;
        check_eq("rw_data_data_ok", 32'(data_data_ok), 1);
        check_eq("rw_inst_data_ok0", 32'(inst_data_ok), 0);
        check_eq("rw_data_rdata", data_rdata, 32'h0);
        step();

        // Stray response with nothing outstanding is dropped.
        #1;
        check_eq("err_inst_data_ok", 32'(inst_data_ok), 0);
        check_eq("err_data_data_ok", 32'(data_data_ok), 0);
        step();
        check_eq("err_count", fifo_count(), 0);
        mem_data_ok = 1'b0;

        // Push+pop each cycle at count 1 across 8 pointer wraps.
        inst_req  = 1'b1;
        inst_addr = 32'h6000;
        step();
        model.push_back(1'b0);
        inst_req = 1'b0;
        check_eq("wrap_start_count", fifo_count(), 1);
        for (int i = 0; i < 16; i++) begin
            src         = (i % 2 == 0);
            inst_req    = ~src;
            data_req    = src;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'(i);
            #1;
            exp_tag = model.pop_front();
            check_eq("wrap_inst_data_ok", 32'(inst_data_ok), 32'(!exp_tag));
            check_eq("wrap_data_data_ok", 32'(data_data_ok), 32'(exp_tag));
            model.push_back(src);
            step();
            check_eq("wrap_count", fifo_count(), 1);
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        #1;
        exp_tag = model.pop_front();
        check_eq("wrap_last_data_data_ok", 32'(data_data_ok), 32'(exp_tag));
        step();
        mem_data_ok = 1'b0;
        check_eq("wrap_end_count", fifo_count(), 0);

        // Reset with two outstanding discards the tags.
        inst_req = 1'b1;
        step();
        inst_req = 1'b0;
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        check_eq("rst2_count_before", fifo_count(), 2);
        resetn = 1'b0;
        #1;
        check_eq("rst2_count_async", fifo_count(), 0);
        step();
        resetn = 1'b1;
        step();
        mem_data_ok = 1'b1;
        #1;
        check_eq("rst2_inst_data_ok", 32'(inst_data_ok), 0);
        check_eq("rst2_data_data_ok", 32'(data_data_ok), 0);
        step();
        check_eq("rst2_count_after", fifo_count(), 0);
        mem_data_ok = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
